rv_io_initiator: RTL and testbench
==================================

Name: rv_io_initiator

Overview:
CPU-side initiator for the split-transaction IO bus. It accepts one load/store at a time from the CPU load/store unit, drives the address phase (addr_req/addr_ack), and collects the read data phase (data_req/data_ack). It returns completion, data and error status to the CPU. A timeout stops a missing or hung responder from stalling the CPU.

Parameters:
RV, 64, data width (bits); must be a multiple of 8
AW, 12, IO address width
TIMEOUT, 1024, cycles allowed per phase before error; 0 disables timeout
TW, 16, timeout counter width; TIMEOUT < 2**TW

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU request valid
cpu_ack  output  1  request accepted this cycle
cpu_addr  input  AW  request address
cpu_read  input  1  1=load, 0=store
cpu_wdata  input  RV  store data
cpu_mask  input  RV/8  store byte enables
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  1  valid with cpu_done; 1=timeout
cpu_rdata  output  RV  load data; valid with cpu_done
addr_req  output  1  bus address-phase request
addr_ack  input  1  responder accepts the address phase
addr  output  AW  bus address
read  output  1  bus read strobe
wdata  output  RV  bus write data
wmask  output  RV/8  bus byte enables
data_req  input  1  responder has read data
data_ack  output  1  read data consumed
rdata  input  RV  responder read data

Behaviour:
- Reset: clock is clk; reset is synchronous, active-high.
  - Values after reset: state IDLE; addr_req=0, cpu_done=0, cpu_err=0, data_ack=0, cpu_ack=0; cpu_rdata=0; addr/read/wdata/wmask=0; timeout counter=0.
  - Reset mid-transaction abandons it with no cpu_done.
  - A responder left holding data_req is drained by the stale-data rule below.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cpu_ack = cpu_req (combinational).
  - On cpu_req, register addr, read, wdata and wmask from the cpu_* inputs, then go to ADDR.
  - cpu_ack=0 in all other states.
- ADDR:
  - addr_req=1; addr/read/wdata/wmask held stable.
  - When addr_req && addr_ack at a clock edge: read goes to DATA, write goes to RESP (writes are posted).
  - addr_req drops in the cycle after the ack.
- DATA:
  - data_ack = data_req (combinational).
  - On an edge with data_req=1, capture rdata into cpu_rdata, clear err, go to RESP.
- RESP:
  - cpu_done=1 for exactly one cycle, then go to IDLE.
  - Writes: cpu_rdata holds its previous value and is don't-care.
- Minimum latency, responder acking combinationally:
  - Write: cpu_ack at cycle 0, addr_req cycle 1, cpu_done cycle 2.
  - Read with data_req at cycle 2: cpu_done cycle 3.
  - Back-to-back: the next cpu_ack is possible in the cycle after cpu_done.
- Timeout:
  - Counter clears on entry to ADDR and to DATA, and increments each cycle in those states.
  - When counter == TIMEOUT-1 without progress: go to RESP with cpu_err=1 and cpu_rdata all ones; addr_req deasserts.
  - If progress and timeout coincide on the same edge, progress wins.
  - TIMEOUT=0: the counter never triggers.
- Stale data:
  - In IDLE, ADDR and RESP, data_ack = data_req; the data is discarded and the state is unchanged.
  - This drains responses that arrive after a timeout.
  - Such a response arriving during a later DATA state is indistinguishable from the real one and is accepted. This is a known limitation; software must not reissue to a timed-out device.
- cpu_* inputs are sampled only on the cpu_ack cycle; later changes are ignored.

Test Plan:
- Write, responder with addr_ack=addr_req&&1: cpu_addr=0x010, mask=0xFF, wdata=0x1122334455667788 -> addr_req high 1 cycle with addr=0x010, read=0, wmask=0xFF; cpu_done two cycles after cpu_ack, cpu_err=0; data_ack never high.
- Read, data_req raised 3 cycles after addr_ack with rdata=0xDEADBEEF00C0FFEE -> data_ack high the same cycle; cpu_done next cycle with cpu_rdata=0xDEADBEEF00C0FFEE, cpu_err=0.
- Address-phase timeout, TIMEOUT=8, addr_ack tied 0 -> addr_req high exactly 8 cycles, then cpu_done with cpu_err=1 and cpu_rdata=all ones.
- Data-phase timeout, TIMEOUT=8, then data_req raised 5 cycles after cpu_done -> cpu_err=1; the stale data_req is acked within 1 cycle in IDLE; a following good read returns correct data.
- Reset asserted in DATA, then data_req held high -> no cpu_done; all outputs at reset values; data_ack follows data_req and drains it.
- Back-to-back: 4 reads at addresses 0x000/0x008/0x010/0x018 with cpu_req held high -> each cpu_ack one cycle after the previous cpu_done; rdata returned in order; cpu_ack never high outside IDLE.

Source files
------------

// File: rtl/rv_io_initiator.sv
// CPU-side initiator for the split-transaction IO bus: one load/store at a time,
// address phase, optional read-data phase, completion pulse, per-phase timeout.
module rv_io_initiator #(
  parameter int unsigned RV      = 64,
  parameter int unsigned AW      = 12,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  output logic            cpu_ack,
  input  logic [AW-1:0]   cpu_addr,
  input  logic            cpu_read,
  input  logic [RV-1:0]   cpu_wdata,
  input  logic [RV/8-1:0] cpu_mask,
  output logic            cpu_done,
  output logic            cpu_err,
  output logic [RV-1:0]   cpu_rdata,
  output logic            addr_req,
  input  logic            addr_ack,
  output logic [AW-1:0]   addr,
  output logic            read,
  output logic [RV-1:0]   wdata,
  output logic [RV/8-1:0] wmask,
  input  logic            data_req,
  output logic            data_ack,
  input  logic [RV-1:0]   rdata
);

  localparam int unsigned MW    = RV / 8;
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            read_q, read_d;
  logic [RV-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [RV-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            expire;

  assign expire = TO_EN && (cnt_q == TW'(TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and handshake logic; progress takes priority over expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cpu_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_ack = cpu_req;
        if (cpu_req) begin
          addr_d  = cpu_addr;
          read_d  = cpu_read;
          wdata_d = cpu_wdata;
          wmask_d = cpu_mask;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (addr_ack) begin
          cnt_d   = '0;
          state_d = read_q ? DATA : RESP;
          if (!read_q) err_d = 1'b0;
        end else if (expire) begin
          err_d   = 1'b1;
          rdata_d = '1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DATA: begin
        if (data_req) begin
          rdata_d = rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expire) begin
          err_d   = 1'b1;
          rdata_d = '1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is consumed in every state; outside DATA it is stale and dropped
  assign data_ack  = data_req;
  assign addr_req  = (state_q == ADDR);
  assign cpu_done  = (state_q == RESP);
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign addr      = addr_q;
  assign read      = read_q;
  assign wdata     = wdata_q;
  assign wmask     = wmask_q;

endmodule

// File: tb/tb_rv_io_initiator.sv
// Bench for rv_io_initiator: transaction-level model checked every cycle plus
// directed scenarios with hand-computed latencies and data.
module tb_rv_io_initiator;

  localparam int unsigned RV = 64;
  localparam int unsigned AW = 12;
  localparam int unsigned MW = RV / 8;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned TW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 1'b0, cpu_ack, cpu_read = 1'b0, cpu_done, cpu_err;
  logic [AW-1:0] cpu_addr = '0, addr;
  logic [RV-1:0] cpu_wdata = '0, cpu_rdata, wdata, rdata;
  logic [MW-1:0] cpu_mask = '0, wmask;
  logic addr_req, addr_ack, read, data_req, data_ack;

  logic auto_ack = 1'b0, man_ack = 1'b0;
  logic auto_data = 1'b0, man_req = 1'b0, rsp_req = 1'b0;
  logic [RV-1:0] man_rdata = '0, rsp_data = '0;

  assign addr_ack = auto_ack ? addr_req : man_ack;
  assign data_req = auto_data ? rsp_req : man_req;
  assign rdata    = auto_data ? rsp_data : man_rdata;

  rv_io_initiator #(.RV(RV), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_addr(cpu_addr), .cpu_read(cpu_read),
    .cpu_wdata(cpu_wdata), .cpu_mask(cpu_mask), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .addr_req(addr_req), .addr_ack(addr_ack), .addr(addr),
    .read(read), .wdata(wdata), .wmask(wmask), .data_req(data_req), .data_ack(data_ack),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [RV-1:0] pat(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  // Auto responder: returns pat(addr) the cycle after an accepted read address
  always @(posedge clk) begin
    rsp_req  <= addr_req && addr_ack && read;
    rsp_data <= pat(addr);
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  int ack_cnt = 0, ack_cyc = 0, done_cnt = 0, done_cyc = 0, dack_cnt = 0, dack_cyc = 0;
  int addr_hi = 0;
  logic last_err = 1'b0;
  logic [RV-1:0] last_rdata = '0;
  logic [RV-1:0] done_q[$];

  // Model: phase 0 idle, 1 address, 2 read data, 3 response
  bit m_valid = 1'b0;
  int m_ph = 0, m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic m_read = 1'b0, m_err = 1'b0;
  logic [RV-1:0] m_wdata = '0, m_rdata = '0;
  logic [MW-1:0] m_mask = '0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("data_ack", 64'(data_ack), 64'(data_req));
      chk("cpu_ack", 64'(cpu_ack), 64'(cpu_req && m_ph == 0));
      chk("addr_req", 64'(addr_req), 64'(m_ph == 1));
      chk("cpu_done", 64'(cpu_done), 64'(m_ph == 3));
      if (m_ph == 1) begin
        chk("addr", 64'(addr), 64'(m_addr));
        chk("read", 64'(read), 64'(m_read));
        chk("wdata", wdata, m_wdata);
        chk("wmask", 64'(wmask), 64'(m_mask));
      end
      if (m_ph == 3) begin
        chk("cpu_err", 64'(cpu_err), 64'(m_err));
        if (m_read || m_err) chk("cpu_rdata", cpu_rdata, m_rdata);
      end
    end
    if (cpu_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (cpu_done) begin
      done_cnt++; done_cyc = cyc; last_err = cpu_err; last_rdata = cpu_rdata;
      done_q.push_back(cpu_rdata);
    end
    if (data_ack) begin dack_cnt++; dack_cyc = cyc; end
    if (addr_req) addr_hi++;
    if (reset) begin
      m_valid = 1'b1; m_ph = 0; m_rdata = '0; m_err = 1'b0;
    end else if (m_valid) begin
      case (m_ph)
        0: if (cpu_req) begin
          m_ph = 1; m_age = 0;
          m_addr = cpu_addr; m_read = cpu_read; m_wdata = cpu_wdata; m_mask = cpu_mask;
        end
        1: if (addr_ack) begin
          m_ph = m_read ? 2 : 3; m_age = 0;
          if (!m_read) m_err = 1'b0;
        end else if (TIMEOUT != 0 && m_age == int'(TIMEOUT) - 1) begin
          m_ph = 3; m_err = 1'b1; m_rdata = '1;
        end else m_age++;
        2: if (data_req) begin
          m_ph = 3; m_err = 1'b0; m_rdata = rdata;
        end else if (TIMEOUT != 0 && m_age == int'(TIMEOUT) - 1) begin
          m_ph = 3; m_err = 1'b1; m_rdata = '1;
        end else m_age++;
        default: m_ph = 0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int budget, input int target);
    for (int i = 0; i < budget && done_cnt < target; i++) tick(1);
    chk("done_wait", 64'(done_cnt >= target), 64'(1));
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr_req", 64'(addr_req), 64'(0));
    chk("rst_cpu_done", 64'(cpu_done), 64'(0));
    chk("rst_cpu_err", 64'(cpu_err), 64'(0));
    chk("rst_cpu_rdata", cpu_rdata, 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_read", 64'(read), 64'(0));
    chk("rst_wdata", wdata, 64'(0));
    chk("rst_wmask", 64'(wmask), 64'(0));
  endtask

  int d0, a0, dk, q0, dd;

  initial begin
    tick(2);
    reset = 1'b0;
    chk_reset_vals();

    // Posted write with combinational addr_ack
    auto_ack = 1'b1;
    d0 = done_cnt; dk = dack_cnt; a0 = addr_hi;
    cpu_req = 1'b1; cpu_read = 1'b0; cpu_addr = 12'h010;
    cpu_wdata = 64'h1122334455667788; cpu_mask = 8'hFF;
    tick(1);
    cpu_req = 1'b0; cpu_addr = 12'hFFF; cpu_wdata = '1; cpu_mask = 8'h0F;
    wait_done(10, d0 + 1);
    chk("wr_latency", 64'(done_cyc - ack_cyc), 64'(2));
    chk("wr_addr_req_cycles", 64'(addr_hi - a0), 64'(1));
    chk("wr_err", 64'(last_err), 64'(0));
    chk("wr_no_data_ack", 64'(dack_cnt - dk), 64'(0));
    tick(1);

    // Read, data arrives 3 cycles after addr_ack
    cpu_req = 1'b1; cpu_read = 1'b1; cpu_addr = 12'h020;
    tick(1);
    cpu_req = 1'b0;
    tick(3);
    man_req = 1'b1; man_rdata = 64'hDEADBEEF00C0FFEE;
    tick(1);
    man_req = 1'b0;
    wait_done(10, d0 + 2);
    chk("rd_dack_cycle", 64'(dack_cyc - ack_cyc), 64'(4));
    chk("rd_latency", 64'(done_cyc - dack_cyc), 64'(1));
    chk("rd_rdata", last_rdata, 64'hDEADBEEF00C0FFEE);
    chk("rd_err", 64'(last_err), 64'(0));
    tick(1);

    // Address-phase timeout
    auto_ack = 1'b0; man_ack = 1'b0; a0 = addr_hi;
    cpu_req = 1'b1; cpu_read = 1'b1; cpu_addr = 12'h030;
    tick(1);
    cpu_req = 1'b0;
    wait_done(30, d0 + 3);
    chk("ato_addr_req_cycles", 64'(addr_hi - a0), 64'(8));
    chk("ato_latency", 64'(done_cyc - ack_cyc), 64'(9));
    chk("ato_err", 64'(last_err), 64'(1));
    chk("ato_rdata", last_rdata, 64'hFFFFFFFFFFFFFFFF);
    tick(1);

    // Data-phase timeout, then a stale response drained in IDLE
    auto_ack = 1'b1;
    cpu_req = 1'b1; cpu_read = 1'b1; cpu_addr = 12'h038;
    tick(1);
    cpu_req = 1'b0;
    wait_done(30, d0 + 4);
    chk("dto_latency", 64'(done_cyc - ack_cyc), 64'(10));
    chk("dto_err", 64'(last_err), 64'(1));
    chk("dto_rdata", last_rdata, 64'hFFFFFFFFFFFFFFFF);
    dd = done_cyc;
    tick(4);
    man_req = 1'b1; man_rdata = 64'h0BAD0BAD0BAD0BAD;
    tick(1);
    man_req = 1'b0;
    chk("stale_dack_cycle", 64'(dack_cyc), 64'(dd + 5));
    tick(2);
    chk("stale_no_done", 64'(done_cnt), 64'(d0 + 4));
    cpu_req = 1'b1; cpu_read = 1'b1; cpu_addr = 12'h048;
    tick(1);
    cpu_req = 1'b0;
    tick(1);
    man_req = 1'b1; man_rdata = 64'h0123456789ABCDEF;
    tick(1);
    man_req = 1'b0;
    wait_done(10, d0 + 5);
    chk("good_rd_latency", 64'(done_cyc - ack_cyc), 64'(3));
    chk("good_rd_rdata", last_rdata, 64'h0123456789ABCDEF);
    chk("good_rd_err", 64'(last_err), 64'(0));
    tick(1);

    // Reset while waiting for read data, then responder holds data_req
    cpu_req = 1'b1; cpu_read = 1'b1; cpu_addr = 12'h040;
    tick(1);
    cpu_req = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    man_req = 1'b1; man_rdata = 64'h7777777777777777;
    dk = dack_cnt;
    tick(3);
    man_req = 1'b0;
    chk("rst_drain_acks", 64'(dack_cnt - dk), 64'(3));
    chk("rst_no_done", 64'(done_cnt), 64'(d0 + 5));
    chk_reset_vals();
    tick(1);

    // Back-to-back reads with cpu_req held high
    auto_data = 1'b1; q0 = done_q.size();
    cpu_req = 1'b1; cpu_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a0 = ack_cnt;
      cpu_addr = AW'(k * 8);
      for (int i = 0; i < 20 && ack_cnt == a0; i++) tick(1);
      chk("b2b_ack_wait", 64'(ack_cnt > a0), 64'(1));
      if (k > 0) chk("b2b_ack_after_done", 64'(ack_cyc), 64'(done_cyc + 1));
    end
    cpu_req = 1'b0;
    wait_done(20, d0 + 9);
    chk("b2b_count", 64'(done_q.size() - q0), 64'(4));
    for (int k = 0; k < 4; k++)
      if (q0 + k < done_q.size())
        chk("b2b_rdata", done_q[q0 + k], pat(AW'(k * 8)));
    tick(2);

    // Pin the responder pattern used above
    chk("pat_literal", pat(12'h018), 64'hC018C018C018C018);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
